// File: rtl/rv_multicycle_ctrl.sv
// Multicycle RISC-V control FSM: fetch/decode/execute/memory/writeback over one ALU and one memory port.
// Build option RV_MC_BRANCH_EXT_EN enables bne/blt/bge/bltu/bgeu; otherwise only beq is legal.
module rv_multicycle_ctrl #(
   parameter int ALUC_W   = 3,
   parameter int MEM_WAIT = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [6:0]        op,
   input  logic [2:0]        funct3,
   input  logic              f7b5,
   input  logic              zero,
   input  logic              lt,
   input  logic              ltu,
   input  logic              mem_ready,
   output logic              pcwrite,
   output logic              adrsrc,
   output logic              memwrite,
   output logic              irwrite,
   output logic [1:0]        resultsrc,
   output logic [1:0]        alusrca,
   output logic [1:0]        alusrcb,
   output logic [1:0]        immsrc,
   output logic              regwrite,
   output logic [ALUC_W-1:0] alucontrol,
   output logic              illegal
);

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   typedef enum logic [3:0] {
      S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWRITE, S_MEMWB,
      S_EXECR, S_EXECI, S_ALUWB, S_BRANCH, S_JAL
   } state_t;

   state_t      r_state, w_next;
   logic [1:0]  w_aluop;
   logic [2:0]  w_aluc;
   logic        w_rdy;
   logic        w_taken;
   logic        w_br_bad;
   logic        w_alu_bad;

   assign w_rdy = (MEM_WAIT != 0) ? mem_ready : 1'b1;

`ifdef RV_MC_BRANCH_EXT_EN
   always_comb begin
      w_taken  = 1'b0;
      w_br_bad = 1'b0;
      case (funct3)
         3'b000:  w_taken = zero;
         3'b001:  w_taken = !zero;
         3'b100:  w_taken = lt;
         3'b101:  w_taken = !lt;
         3'b110:  w_taken = ltu;
         3'b111:  w_taken = !ltu;
         default: w_br_bad = 1'b1;
      endcase
   end
`else
   logic w_unused_flags;
   assign w_unused_flags = &{1'b0, lt, ltu};
   assign w_taken        = zero;
   assign w_br_bad       = (funct3 != 3'b000);
`endif

   // Shared ALU decode; funct3 codes outside add/sub/slt/or/and fall back to add.
   always_comb begin
      w_aluc    = 3'b000;
      w_alu_bad = 1'b0;
      case (w_aluop)
         2'b00: w_aluc = 3'b000;
         2'b01: w_aluc = 3'b001;
         default: begin
            case (funct3)
               3'b000:  w_aluc = (op[5] & f7b5) ? 3'b001 : 3'b000;
               3'b010:  w_aluc = 3'b101;
               3'b110:  w_aluc = 3'b011;
               3'b111:  w_aluc = 3'b010;
               default: w_aluc = 3'b000;
            endcase
         end
      endcase
      case (funct3)
         3'b000, 3'b010, 3'b110, 3'b111: w_alu_bad = 1'b0;
         default:                        w_alu_bad = 1'b1;
      endcase
   end

   always_comb begin
      alucontrol      = '0;
      alucontrol[2:0] = w_aluc;
   end

   always_comb begin
      case (op)
         OP_STORE:  immsrc = 2'b01;
         OP_BRANCH: immsrc = 2'b10;
         OP_JAL:    immsrc = 2'b11;
         default:   immsrc = 2'b00;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= S_FETCH;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next    = r_state;
      pcwrite   = 1'b0;
      adrsrc    = 1'b0;
      memwrite  = 1'b0;
      irwrite   = 1'b0;
      resultsrc = 2'b00;
      alusrca   = 2'b00;
      alusrcb   = 2'b00;
      regwrite  = 1'b0;
      illegal   = 1'b0;
      w_aluop   = 2'b00;
      case (r_state)
         S_FETCH: begin
            alusrcb   = 2'b10;
            resultsrc = 2'b10;
            irwrite   = w_rdy;
            pcwrite   = w_rdy;
            if (w_rdy) w_next = S_DECODE;
         end
         S_DECODE: begin
            alusrca = 2'b01;
            alusrcb = 2'b01;
            // Illegal encodings drop straight back to FETCH so nothing is written.
            case (op)
               OP_LOAD, OP_STORE: w_next = S_MEMADR;
               OP_RTYPE: begin
                  illegal = w_alu_bad;
                  w_next  = w_alu_bad ? S_FETCH : S_EXECR;
               end
               OP_ITYPE: begin
                  illegal = w_alu_bad;
                  w_next  = w_alu_bad ? S_FETCH : S_EXECI;
               end
               OP_BRANCH: begin
                  illegal = w_br_bad;
                  w_next  = w_br_bad ? S_FETCH : S_BRANCH;
               end
               OP_JAL: w_next = S_JAL;
               default: begin
                  illegal = 1'b1;
                  w_next  = S_FETCH;
               end
            endcase
         end
         S_MEMADR: begin
            alusrca = 2'b10;
            alusrcb = 2'b01;
            w_next  = op[5] ? S_MEMWRITE : S_MEMREAD;
         end
         S_MEMREAD: begin
            adrsrc = 1'b1;
            if (w_rdy) w_next = S_MEMWB;
         end
         S_MEMWRITE: begin
            adrsrc   = 1'b1;
            memwrite = 1'b1;
            if (w_rdy) w_next = S_FETCH;
         end
         S_MEMWB: begin
            resultsrc = 2'b01;
            regwrite  = 1'b1;
            w_next    = S_FETCH;
         end
         S_EXECR: begin
            alusrca = 2'b10;
            w_aluop = 2'b10;
            w_next  = S_ALUWB;
         end
         S_EXECI: begin
            alusrca = 2'b10;
            alusrcb = 2'b01;
            w_aluop = 2'b10;
            w_next  = S_ALUWB;
         end
         S_ALUWB: begin
            regwrite = 1'b1;
            w_next   = S_FETCH;
         end
         S_BRANCH: begin
            alusrca = 2'b10;
            w_aluop = 2'b01;
            pcwrite = w_taken;
            w_next  = S_FETCH;
         end
         S_JAL: begin
            alusrca = 2'b01;
            alusrcb = 2'b10;
            pcwrite = 1'b1;
            w_next  = S_ALUWB;
         end
         default: w_next = S_FETCH;
      endcase
      // State is already FETCH under reset; only the strobes need suppressing.
      if (reset) begin
         pcwrite  = 1'b0;
         irwrite  = 1'b0;
         memwrite = 1'b0;
         regwrite = 1'b0;
         illegal  = 1'b0;
      end
   end

endmodule
